x8_seq_div: RTL

- Sequential restoring divider; the inverse of the x4 multiplier path. Divides an 8-bit dividend (product domain) by a 4-bit divisor (operand domain), one quotient bit per clock.
- Produces an 8-bit quotient and an 8-bit residual.
- Sits beside the approximate multipliers so firmware and bench can recover operands and measure multiplier error.
- Parameterised approximation drops low quotient bits to trade accuracy for latency.

---
 rtl/x8_seq_div_if.sv | 23 ++
 rtl/x8_seq_div.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/x8_seq_div_if.sv
// Handshake bundle for x8_seq_div: operand request channel and result channel.
// The master side issues operands and accepts results; the slave side is the divider.
interface x8_seq_div_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] dividend;
  logic [3:0] divisor;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] quotient;
  logic [7:0] residual;
  logic       div_by_zero;

  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, residual, div_by_zero
  );

  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, residual, div_by_zero
  );
endinterface

// File: rtl/x8_seq_div.sv
// Sequential restoring divider (8-bit / 4-bit), one quotient bit per clock; N_SKIP low quotient bits are skipped.
// Optional X8_SEQ_DIV_EARLY_EXIT_EN: dividend < divisor finishes in one cycle instead of running the full loop.
module x8_seq_div #(
  parameter int N_SKIP = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  x8_seq_div_if.slave  bus
);

  localparam int         CNT_INIT = 8 - N_SKIP;
  localparam logic [7:0] LOW_MASK = 8'((1 << N_SKIP) - 1);
`ifdef X8_SEQ_DIV_EARLY_EXIT_EN
  localparam bit EARLY_EXIT = 1'b1;
`else
  localparam bit EARLY_EXIT = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  // One restoring step: returns {quotient_bit, next_remainder}.
  function automatic logic [5:0] restore_step(input logic [4:0] r, input logic bit_in,
                                              input logic [3:0] d);
    logic [4:0] r_sh;
    r_sh = {r[3:0], bit_in};
    if (r_sh >= {1'b0, d}) return {1'b1, r_sh - {1'b0, d}};
    else                   return {1'b0, r_sh};
  endfunction

  // Skipped dividend bits never entered the remainder, so they pass straight into the residual.
  function automatic logic [7:0] assemble_residual(input logic [4:0] r, input logic [7:0] dvd);
    logic [12:0] wide;
    wide = {8'b0, r} << N_SKIP;
    return wide[7:0] | (dvd & LOW_MASK);
  endfunction

  state_t     state;
  logic [3:0] cnt;
  logic       byp;
  logic       byp_dz;
  logic       in_ready_r;
  logic       out_valid_r;
  logic [7:0] quotient_r;
  logic [7:0] residual_r;
  logic       dz_r;

  logic [7:0] dvd;
  logic [7:0] dsh;
  logic [3:0] dvs;
  logic [4:0] rem;
  logic [7:0] qacc;

  logic       accept;
  logic [5:0] step;
  logic [7:0] q_nx;

  assign accept = bus.in_valid && in_ready_r;
  assign step   = restore_step(rem, dsh[7], dvs);
  assign q_nx   = {qacc[6:0], step[5]};

  assign bus.in_ready    = in_ready_r;
  assign bus.out_valid   = out_valid_r;
  assign bus.quotient    = quotient_r;
  assign bus.residual    = residual_r;
  assign bus.div_by_zero = dz_r;

  // Datapath: operand latch and iteration registers
  always_ff @(posedge clk) begin
    if (accept) begin
      dvd  <= bus.dividend;
      dsh  <= bus.dividend;
      dvs  <= bus.divisor;
      rem  <= '0;
      qacc <= '0;
    end else if (state == RUN) begin
      dsh  <= {dsh[6:0], 1'b0};
      rem  <= step[4:0];
      qacc <= q_nx;
    end
  end

  // Control FSM with registered handshake and result outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      byp         <= 1'b0;
      byp_dz      <= 1'b0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      quotient_r  <= '0;
      residual_r  <= '0;
      dz_r        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            in_ready_r <= 1'b0;
            state      <= RUN;
            // Bypassed cases spend exactly one RUN cycle so their result lands one edge after accept.
            if (bus.divisor == 4'd0) begin
              byp    <= 1'b1;
              byp_dz <= 1'b1;
              cnt    <= 4'd1;
            end else if (EARLY_EXIT && (bus.dividend < {4'b0, bus.divisor})) begin
              byp    <= 1'b1;
              byp_dz <= 1'b0;
              cnt    <= 4'd1;
            end else begin
              byp    <= 1'b0;
              byp_dz <= 1'b0;
              cnt    <= 4'(CNT_INIT);
            end
          end
        end
        RUN: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            state       <= DONE;
            out_valid_r <= 1'b1;
            if (byp) begin
              quotient_r <= byp_dz ? 8'hFF : 8'h00;
              residual_r <= dvd;
              dz_r       <= byp_dz;
            end else begin
              quotient_r <= q_nx << N_SKIP;
              residual_r <= assemble_residual(step[4:0], dvd);
              dz_r       <= 1'b0;
            end
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
